// File: rtl/mult_pkg.sv
// Shared state encoding, default operand width and Booth recoding constants
// for the radix-2 Booth multiplier.
package mult_pkg;

    localparam int MULT_WIDTH = 32;

    // Pairs of multiplier bits {P[1], P[0]} that call for an add or a subtract.
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration over the 2*WIDTH+3 bit product
// register: optional add/subtract into the upper field, then arithmetic shift right.
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [2*WIDTH+2:0] p,
    input  logic [WIDTH:0]     a_ext,
    input  logic [WIDTH:0]     s_ext,
    output logic [2*WIDTH+2:0] p_next
);

    logic [WIDTH:0]     addend_s;
    logic [WIDTH:0]     upper_s;
    logic [2*WIDTH+2:0] sum_s;

    // Select the addend from the recoded bit pair, accumulate, then shift.
    always_comb begin
        addend_s = {(WIDTH+1){1'b0}};
        case (p[1:0])
            BOOTH_ADD: addend_s = a_ext;
            BOOTH_SUB: addend_s = s_ext;
            default:   addend_s = {(WIDTH+1){1'b0}};
        endcase
        upper_s = p[2*WIDTH+2:WIDTH+2] + addend_s;
        sum_s   = {upper_s, p[WIDTH+1:0]};
        p_next  = {sum_s[2*WIDTH+2], sum_s[2*WIDTH+2:1]};
    end

endmodule

// File: rtl/mult_booth_param.sv
// Iterative radix-2 Booth multiplier (signed or unsigned), WIDTH+2 cycle latency.
// Optional macro MULT_EARLY_ZERO_EN: a zero operand skips the iterations.
module mult_booth_param
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             init,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int PW = 2 * WIDTH + 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH:0]   a_ext_r;
    logic [WIDTH:0]   s_ext_r;
    logic [PW-1:0]    p_r;
    logic [PW-1:0]    p_next_s;
    logic [WIDTH:0]   a_ext_s;
    logic [WIDTH:0]   b_ext_s;
    logic             init_ok_s;
    logic             zero_skip_s;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .p      (p_r),
        .a_ext  (a_ext_r),
        .s_ext  (s_ext_r),
        .p_next (p_next_s)
    );

    // Operand extension by one bit keeps -A representable and the product exact.
    always_comb begin
        if (is_signed) begin
            a_ext_s = {a[WIDTH-1], a};
            b_ext_s = {b[WIDTH-1], b};
        end else begin
            a_ext_s = {1'b0, a};
            b_ext_s = {1'b0, b};
        end
        init_ok_s = init && !stop && (state_r != RUN);
`ifdef MULT_EARLY_ZERO_EN
        zero_skip_s = (a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}});
`else
        zero_skip_s = 1'b0;
`endif
    end

    // Control FSM, Booth datapath registers and registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            a_ext_r <= {(WIDTH+1){1'b0}};
            s_ext_r <= {(WIDTH+1){1'b0}};
            p_r     <= {PW{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= {WIDTH{1'b0}};
            lo      <= {WIDTH{1'b0}};
        end else if (stop) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            a_ext_r <= {(WIDTH+1){1'b0}};
            s_ext_r <= {(WIDTH+1){1'b0}};
            p_r     <= {PW{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= {WIDTH{1'b0}};
            lo      <= {WIDTH{1'b0}};
        end else if (init_ok_s) begin
            // Accepting init in DONE still publishes the finishing result.
            if (state_r == DONE) begin
                hi   <= p_r[2*WIDTH:WIDTH+1];
                lo   <= p_r[WIDTH:1];
                done <= 1'b1;
            end else begin
                done <= 1'b0;
            end
            busy    <= 1'b1;
            a_ext_r <= a_ext_s;
            s_ext_r <= (~a_ext_s) + {{WIDTH{1'b0}}, 1'b1};
            if (zero_skip_s) begin
                state_r <= DONE;
                cnt_r   <= {CNT_W{1'b0}};
                p_r     <= {PW{1'b0}};
            end else begin
                state_r <= RUN;
                cnt_r   <= CNT_LOAD;
                p_r     <= {{(WIDTH+1){1'b0}}, b_ext_s, 1'b0};
            end
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                RUN: begin
                    p_r   <= p_next_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    hi      <= p_r[2*WIDTH:WIDTH+1];
                    lo      <= p_r[WIDTH:1];
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_booth_param.sv
// Self-checking bench for mult_booth_param (WIDTH=32): directed corners, random
// operands against a plain-arithmetic product model, stop, back-to-back and reset.
module tb_mult_booth_param;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         is_signed = 1'b0;
    logic         init = 1'b0;
    logic         stop = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int c0 = 0;
    logic [2*W-1:0] exp_prev = '0;

    mult_booth_param #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .init      (init),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic sg);
        logic [2*W-1:0] ex;
        logic [2*W-1:0] ey;
        ex = sg ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        ey = sg ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        return ex * ey;
    endfunction

    function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MULT_EARLY_ZERO_EN
        if (x == '0 || y == '0) return 1;
`endif
        return W + 2;
    endfunction

    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sg);
        @(negedge clk);
        a = av;
        b = bv;
        is_signed = sg;
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        c0 = cyc;
    endtask

    // Waits for done (bounded), returns latency from c0 or -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 0; k < 100 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (done) lat = cyc - c0;
        end
    endtask

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sg,
                         output int lat, output logic [2*W-1:0] mid, output logic [2*W-1:0] res,
                         output logic bsy_at_done, output logic dn_after);
        start_op(av, bv, sg);
        mid = {hi, lo};
        lat = -1;
        for (int k = 1; k <= 100 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 2 && !done) mid = {hi, lo};
            if (done) lat = cyc - c0;
        end
        res = {hi, lo};
        bsy_at_done = busy;
        @(posedge clk);
        #1;
        dn_after = done;
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
    endtask

    task automatic test_reset();
        int cnt;
        #12;
        checks++;
        if ({busy, done, hi, lo} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h expected=0", {busy, done, hi, lo});
        end
        @(negedge clk);
        rst = 1'b1;
        count_done(3, cnt);
        checks++;
        if (cnt != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got done_count=%0d busy=%b expected 0/0", cnt, busy);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] xs [5] = '{32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        logic [W-1:0] ys [5] = '{32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0005};
        logic         ss [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [2*W-1:0] ex [5] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFE_0000_0001,
                                   64'h0000_0000_0000_0001, 64'h4000_0000_0000_0000,
                                   64'h0000_0000_0000_0000};
        int lat;
        logic [2*W-1:0] mid, res;
        logic bd, da;
        for (int i = 0; i < 5; i++) begin
            do_op(xs[i], ys[i], ss[i], lat, mid, res, bd, da);
            checks++;
            if (lat != exp_lat(xs[i], ys[i])) begin
                failures++;
                $display("FAIL directed_latency[%0d] got=%0d expected=%0d", i, lat, exp_lat(xs[i], ys[i]));
            end
            checks++;
            if (res !== ex[i]) begin
                failures++;
                $display("FAIL directed_product[%0d] got=%h expected=%h", i, res, ex[i]);
            end
            checks++;
            if (bd !== 1'b0 || da !== 1'b0) begin
                failures++;
                $display("FAIL directed_pulse[%0d] busy_at_done=%b done_after=%b expected 0/0", i, bd, da);
            end
            exp_prev = ex[i];
        end
    endtask

    task automatic test_random();
        int lat;
        logic [2*W-1:0] mid, res, e;
        logic bd, da, sg;
        logic [W-1:0] x, y;
        for (int i = 0; i < 24; i++) begin
            x = $urandom();
            y = $urandom();
            case ($urandom_range(0, 7))
                0: x = '0;
                1: y = '1;
                2: x = 32'h8000_0000;
                3: y = 32'h8000_0000;
                default: ;
            endcase
            sg = 1'($urandom_range(0, 1));
            e = model(x, y, sg);
            do_op(x, y, sg, lat, mid, res, bd, da);
            checks++;
            if (lat != exp_lat(x, y)) begin
                failures++;
                $display("FAIL random_latency[%0d] got=%0d expected=%0d", i, lat, exp_lat(x, y));
            end
            checks++;
            if (res !== e) begin
                failures++;
                $display("FAIL random_product[%0d] a=%h b=%h s=%b got=%h expected=%h", i, x, y, sg, res, e);
            end
            checks++;
            if (mid !== exp_prev) begin
                failures++;
                $display("FAIL random_hold_during_run[%0d] got=%h expected=%h", i, mid, exp_prev);
            end
            checks++;
            if (bd !== 1'b0 || da !== 1'b0) begin
                failures++;
                $display("FAIL random_pulse[%0d] busy_at_done=%b done_after=%b expected 0/0", i, bd, da);
            end
            exp_prev = e;
        end
    endtask

    task automatic test_stop();
        int cnt;
        start_op(32'h1234_5678, 32'h0000_0ABC, 1'b0);
        while (cyc < c0 + 10) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        checks++;
        if ({busy, done, hi, lo} !== '0) begin
            failures++;
            $display("FAIL stop_in_run got busy/done/hi/lo=%h expected=0", {busy, done, hi, lo});
        end
        count_done(40, cnt);
        checks++;
        if (cnt != 0) begin
            failures++;
            $display("FAIL stop_no_done got done_count=%0d expected=0", cnt);
        end
        // Produce a nonzero result, then stop together with init while idle.
        start_op(32'h0000_0013, 32'h0000_0011, 1'b0);
        wait_done(cnt);
        checks++;
        if ({hi, lo} !== 64'd323) begin
            failures++;
            $display("FAIL stop_setup_product got=%h expected=%h", {hi, lo}, 64'd323);
        end
        @(negedge clk);
        a = 32'h5;
        b = 32'h7;
        init = 1'b1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        stop = 1'b0;
        checks++;
        if ({busy, hi, lo} !== '0) begin
            failures++;
            $display("FAIL stop_wins_idle got busy/hi/lo=%h expected=0", {busy, hi, lo});
        end
        count_done(40, cnt);
        checks++;
        if (cnt != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stop_init_discarded got done_count=%0d busy=%b expected 0/0", cnt, busy);
        end
        exp_prev = '0;
    endtask

    task automatic test_init_during_run();
        int lat;
        logic [2*W-1:0] e;
        e = model(32'hDEAD_BEEF, 32'h0000_1234, 1'b1);
        start_op(32'hDEAD_BEEF, 32'h0000_1234, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        a = 32'h0000_0002;
        b = 32'h0000_0003;
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        wait_done(lat);
        checks++;
        if (lat != W + 2) begin
            failures++;
            $display("FAIL init_in_run_latency got=%0d expected=%0d", lat, W + 2);
        end
        checks++;
        if ({hi, lo} !== e) begin
            failures++;
            $display("FAIL init_in_run_product got=%h expected=%h", {hi, lo}, e);
        end
        exp_prev = e;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [2*W-1:0] e1, e2;
        logic [W-1:0] x, y;
        // Second init issued in the cycle where done is high.
        start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done(lat);
        checks++;
        if ({hi, lo} !== 64'h4000_0000_0000_0000 || lat != W + 2) begin
            failures++;
            $display("FAIL b2b_first got=%h lat=%0d expected=%h lat=%0d", {hi, lo}, lat,
                     64'h4000_0000_0000_0000, W + 2);
        end
        x = $urandom() | 32'h1;
        y = $urandom() | 32'h1;
        e2 = model(x, y, 1'b0);
        a = x;
        b = y;
        is_signed = 1'b0;
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        c0 = cyc;
        wait_done(lat);
        checks++;
        if (lat != W + 2 || {hi, lo} !== e2) begin
            failures++;
            $display("FAIL b2b_on_done_cycle got=%h lat=%0d expected=%h lat=%0d", {hi, lo}, lat, e2, W + 2);
        end
        // Next init arrives while the FSM sits in DONE, on the done edge itself.
        @(posedge clk);
        #1;
        e1 = model(x, y, 1'b1);
        start_op(x, y, 1'b1);
        while (cyc < c0 + W + 1) begin
            @(posedge clk);
            #1;
        end
        a = 32'h0000_0000;
        b = 32'hFFFF_FFF0;
        is_signed = 1'b1;
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || {hi, lo} !== e1) begin
            failures++;
            $display("FAIL b2b_in_done got done=%b busy=%b prod=%h expected 1/1/%h", done, busy, {hi, lo}, e1);
        end
        c0 = cyc;
        lat = -1;
        for (int k = 0; k < 100 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (done) lat = cyc - c0;
        end
        checks++;
        if (lat != exp_lat(32'h0, 32'hFFFF_FFF0) || {hi, lo} !== '0) begin
            failures++;
            $display("FAIL b2b_in_done_second got=%h lat=%0d expected=0 lat=%0d", {hi, lo}, lat,
                     exp_lat(32'h0, 32'hFFFF_FFF0));
        end
        exp_prev = '0;
    endtask

    task automatic test_async_reset();
        int cnt;
        start_op(32'h0000_0100, 32'h0000_0100, 1'b0);
        wait_done(cnt);
        checks++;
        if ({hi, lo} !== 64'h0000_0000_0001_0000) begin
            failures++;
            $display("FAIL async_setup_product got=%h expected=%h", {hi, lo}, 64'h0000_0000_0001_0000);
        end
        @(posedge clk);
        start_op(32'h0BAD_F00D, 32'h0000_7777, 1'b1);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== '0) begin
            failures++;
            $display("FAIL async_reset_immediate got=%h expected=0", {busy, done, hi, lo});
        end
        @(negedge clk);
        rst = 1'b1;
        count_done(40, cnt);
        checks++;
        if (cnt != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_no_done got done_count=%0d busy=%b expected 0/0", cnt, busy);
        end
        exp_prev = '0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stop();
        test_init_during_run();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
